// File: rtl/jt12_ampctrl.sv
// rtl/jt12_ampctrl.sv - adaptive-gain saturating shift amplifier for the FM output stage
//
// Purpose: on each sample strobe, shift a stereo pair left by the current
// gain (saturating on overflow) and register it. The gain drops one step
// per clipping sample and rises one step after `hold` clean samples if the
// current sample has headroom. Manual mode loads a fixed shift instead.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sample                one-cycle strobe, left_in/right_in valid
//   gain_en               1 = adaptive gain, 0 = fixed shift from cfg_shift
//   cfg_shift[2:0]        manual shift, clamped to max_shift
//   left_in, right_in     signed mixer samples
//   left_out, right_out   registered amplified/saturated samples
//   out_valid             one-cycle pulse one clk after sample
//   shift_out[2:0]        shift that the next sample will use
//   clip                  one-cycle pulse with out_valid when a channel saturated
module jt12_ampctrl #(
   parameter int width     = 20,
   parameter int max_shift = 5,
   parameter int hold      = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sample,
   input  logic                    gain_en,
   input  logic [2:0]              cfg_shift,
   input  logic signed [width-1:0] left_in,
   input  logic signed [width-1:0] right_in,
   output logic signed [width-1:0] left_out,
   output logic signed [width-1:0] right_out,
   output logic                    out_valid,
   output logic [2:0]              shift_out,
   output logic                    clip
);

   localparam int HCW = (hold > 1) ? $clog2(hold) : 1;
   localparam logic [HCW-1:0] HOLD_TOP = HCW'(hold - 1);
   localparam logic [2:0] MAX_S = 3'(max_shift);
   localparam logic signed [width-1:0] SAT_POS = {1'b0, {(width-1){1'b1}}};
   localparam logic signed [width-1:0] SAT_NEG = {1'b1, {(width-1){1'b0}}};

   typedef enum logic [1:0] {S_TRACK, S_ATTACK, S_MAX} state_t;

   state_t                  r_state, w_state_nxt;
   logic [2:0]              r_shift, w_shift_nxt;
   logic [HCW-1:0]          r_hold_cnt, w_hold_nxt, w_hold_inc;
   logic [2:0]              w_shift_up, w_shift_dn, w_cfg_clamped;
   logic                    w_clip_l, w_clip_r, w_clip_any, w_headroom;
   logic signed [width-1:0] w_left_amp, w_right_amp;

   // A channel clips at shift s when its top s+1 bits are not all equal,
   // i.e. the arithmetic right shift leaving those bits is neither 0 nor -1.
   function automatic logic f_clips(input logic signed [width-1:0] x, input logic [2:0] s);
      logic signed [width-1:0] t;
      t = x >>> (width - 1 - int'(s));
      return !((t == '0) || (t == '1));
   endfunction

   assign w_shift_up    = r_shift + 3'd1;
   assign w_shift_dn    = (r_shift != 3'd0) ? r_shift - 3'd1 : 3'd0;
   assign w_cfg_clamped = (cfg_shift > MAX_S) ? MAX_S : cfg_shift;
   assign w_hold_inc    = (r_hold_cnt == HOLD_TOP) ? r_hold_cnt : r_hold_cnt + HCW'(1);
   assign w_clip_l      = f_clips(left_in, r_shift);
   assign w_clip_r      = f_clips(right_in, r_shift);
   assign w_clip_any    = w_clip_l | w_clip_r;
   // Step-up is judged on the current (clean) sample at one more shift.
   // w_shift_up may wrap at 7, but is then masked by the max_shift test.
   assign w_headroom    = (r_shift < MAX_S) && !f_clips(left_in, w_shift_up)
                          && !f_clips(right_in, w_shift_up);
   assign shift_out     = r_shift;

   // State register plus output data registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_MAX;
         r_shift    <= MAX_S;
         r_hold_cnt <= '0;
         left_out   <= '0;
         right_out  <= '0;
         out_valid  <= 1'b0;
         clip       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_hold_cnt <= w_hold_nxt;
         out_valid  <= sample;
         clip       <= sample & w_clip_any;
         if (sample) begin
            left_out  <= w_left_amp;
            right_out <= w_right_amp;
         end
      end
   end

   // Next-state logic; nothing moves without a strobe
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_hold_nxt  = r_hold_cnt;
      if (sample) begin
         if (!gain_en) begin
            w_state_nxt = S_TRACK;
            w_shift_nxt = w_cfg_clamped;
            w_hold_nxt  = '0;
         end else if (w_clip_any) begin
            // Any state: one step down per clipping sample
            w_state_nxt = S_ATTACK;
            w_shift_nxt = w_shift_dn;
            w_hold_nxt  = '0;
         end else begin
            case (r_state)
               S_TRACK: begin
                  if (r_hold_cnt != HOLD_TOP) begin
                     w_hold_nxt = r_hold_cnt + HCW'(1);
                  end else if (w_headroom) begin
                     w_shift_nxt = w_shift_up;
                     w_hold_nxt  = '0;
                     if (w_shift_up == MAX_S) w_state_nxt = S_MAX;
                  end
               end
               S_ATTACK: begin
                  w_hold_nxt  = w_hold_inc;
                  w_state_nxt = S_TRACK;
               end
               S_MAX: w_hold_nxt = '0;
               default: w_state_nxt = S_TRACK;
            endcase
         end
      end
   end

   // Output datapath: saturate by sign on clip, else shift by current gain
   always_comb begin
      w_left_amp  = left_in <<< r_shift;
      w_right_amp = right_in <<< r_shift;
      if (w_clip_l) w_left_amp  = left_in[width-1]  ? SAT_NEG : SAT_POS;
      if (w_clip_r) w_right_amp = right_in[width-1] ? SAT_NEG : SAT_POS;
   end

endmodule
